cnn_ot_streamer: RTL and testbench
==================================

# cnn_ot_streamer

Output-side unloader for `cnn_topCore`. It captures the full-width `o_ot_fmap` result bus on an `o_ot_valid` pulse. It then streams the result out one `DATA_LEN` element per transfer over a valid/ready interface, in the same (in, och, oy, ox) order the result trace files use. It lets a narrow consumer (DMA, UART bridge, FIFO) read results without fanning out the full result bus.

## Interface
- `IN`, default 1: batch count.
- `OCH`, default 2: output channels.
- `OX`, default 2: output width.
- `OY`, default 2: output height.
- `DATA_LEN`, default 8: element width in bits.
- `TOTAL` (localparam) = `IN*OCH*OY*OX`.
- `clk` input 1: single clock. All logic is on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `i_soft_reset` input 1: synchronous clear. Same effect as `reset`, applied at the clock edge.
- `i_in_valid` input 1: one-cycle capture strobe. Driven by `cnn_topCore.o_ot_valid`.
- `i_in_fmap` input `IN*OCH*OX*OY*DATA_LEN`: result bus. Driven by `o_ot_fmap`.
- `o_valid` output 1: an element is presented.
- `i_ready` input 1: the consumer accepts the element.
- `o_data` output `DATA_LEN`: the current element.
- `o_first` output 1: the element is at ox=0, oy=0 of an (in, och) plane.
- `o_last` output 1: the element is the final element (k = `TOTAL`-1).
- `o_idx_in` output `$clog2(IN)` (min 1): batch index of the element.
- `o_idx_och` output `$clog2(OCH)` (min 1): channel index of the element.
- `o_busy` output 1: a frame is held or streaming.
- `o_overflow` output 1: sticky flag. A capture strobe was dropped.

## Operation
- **Element order:** k = ((in·OCH + och)·OY + oy)·OX + ox. `o_data` = `i_in_fmap[k*DATA_LEN +: DATA_LEN]` of the captured frame.
- **FSM states:**
  - IDLE: `o_valid`=0, `o_busy`=0.
  - STREAM: `o_valid`=1, `o_busy`=1.
- **IDLE to STREAM:** on `i_in_valid`. The bus is copied into the capture register and all counters are set to 0.
- **Counters:** four nested counters (ox innermost, then oy, och, in). They advance only on a handshake (`o_valid && i_ready`). Each counter wraps at its bound and carries to the next.
- **End of frame:** the handshake with `o_last`=1 returns the FSM to IDLE, unless a new frame is accepted on that edge (see Timing).
- **Stability:** while `o_valid && !i_ready`, the outputs `o_data`, `o_first`, `o_last` and both indices must hold stable.
- **Capture eligibility:** a capture is allowed when the FSM is in IDLE, or when the `o_last` handshake occurs on the same edge.
- **Dropped strobe:** an `i_in_valid` arriving at any other time is discarded and `o_overflow` is set. The frame currently streaming is unaffected.
- **Clearing overflow:** `o_overflow` is cleared only by `reset` or `i_soft_reset`.
- **No arithmetic:** data is passed through bit-exact.

## Timing
- **Reset values:**
  - All of `o_valid`, `o_first`, `o_last`, `o_busy`, `o_overflow` = 0.
  - `o_data`, `o_idx_in`, `o_idx_och` = 0.
  - FSM in IDLE, capture register cleared.
- **Latency:** `i_in_valid` sampled at edge N gives `o_valid`=1 with element 0 during cycle N+1.
- **Throughput:** with `i_ready` held at 1, one element per cycle. The last element is presented in cycle N+`TOTAL`. `o_valid` is 0 in cycle N+`TOTAL`+1.
- **Back-to-back frames:** a capture accepted on the `o_last` handshake edge presents element 0 of the new frame in the next cycle, with no bubble.
- **`i_ready` while `o_valid`=0:** ignored.
- **Reset mid-frame:** `reset` asserted during STREAM drops `o_valid` immediately (asynchronously). `i_soft_reset` drops it at the next edge. The partial frame is discarded and the consumer sees no `o_last`.
- **Reset priority:** `reset` and `i_soft_reset` take priority over a simultaneous `i_in_valid`.

## Configuration
- **`CNN_OT_STREAM_DBL_BUF_EN` defined:**
  - A second holding register is added.
  - An `i_in_valid` during STREAM (other than on the last handshake) is stored in the holding register if it is empty.
  - At the `o_last` handshake, the held frame moves to the capture register and streams from element 0 in the next cycle, with no bubble.
  - `o_busy` stays 1 while either register is occupied.
  - `o_overflow` is set only when a strobe arrives while both registers are full.
- **Undefined:** single register only, with the drop behaviour described in Operation.

## Test plan
All scenarios use IN=1, OCH=2, OX=2, OY=2, DATA_LEN=8 (`TOTAL`=8), with element k of the bus = k+1.

1. **Basic stream.** `i_ready`=1 and a single `i_in_valid`.
   - Required: `o_data` = 1..8 in cycles N+1..N+8.
   - Required: `o_first` high on k=0 and k=4. `o_idx_och` = 0,0,0,0,1,1,1,1. `o_last` high only on k=7.
   - Required: `o_valid` low in cycle N+9.
2. **Backpressure.** `i_ready` toggles 1,0,0,1,...
   - Required: `o_data` holds during each stall. All 8 values are delivered once each, in order, with no duplicates.
3. **Overflow.** Second strobe at element 3 (macro undefined).
   - Required: `o_overflow`=1. Elements 1..8 of the first frame complete unchanged, then the FSM returns to IDLE.
   - Required: `i_soft_reset` then clears `o_overflow` to 0.
4. **Seamless restart.** Second strobe on the `o_last` handshake edge, with bus = 0xA0+k.
   - Required: the next cycle shows `o_data`=0xA0 with `o_first`=1, and `o_overflow` stays 0.
5. **Async reset mid-frame.** `reset` asserted at element 5.
   - Required: `o_valid`=0 and `o_busy`=0 before the next edge, with no `o_last` seen.
   - Required: a new strobe afterwards restarts the stream at element 0.
6. **Double buffer** (`CNN_OT_STREAM_DBL_BUF_EN` defined). Strobe at element 2 with bus = 0x40+k.
   - Required: after frame-1 element 8, the next cycle shows 0x40, with no bubble and `o_overflow`=0.
   - Required: a third strobe while both registers are full sets `o_overflow`=1.

Source files
------------

// File: rtl/cnn_ot_streamer_if.sv
// Element stream from cnn_ot_streamer to a narrow consumer: one DATA_LEN element per valid/ready transfer.
// The master side (the streamer) drives the element and its tags, and the slave side returns i_ready.
interface cnn_ot_streamer_if #(
  parameter int DATA_LEN = 8,
  parameter int IN_W     = 1,
  parameter int OCH_W    = 1
);
  logic                o_valid;
  logic                i_ready;
  logic [DATA_LEN-1:0] o_data;
  logic                o_first;
  logic                o_last;
  logic [IN_W-1:0]     o_idx_in;
  logic [OCH_W-1:0]    o_idx_och;

  modport master (
    output o_valid, o_data, o_first, o_last, o_idx_in, o_idx_och,
    input  i_ready
  );

  modport slave (
    input  o_valid, o_data, o_first, o_last, o_idx_in, o_idx_och,
    output i_ready
  );
endinterface

// File: rtl/cnn_ot_streamer.sv
// Captures the full cnn_topCore result bus on a strobe and streams it out one element per handshake in (in, och, oy, ox) order.
// Defining CNN_OT_STREAM_DBL_BUF_EN adds a holding register, so one frame can wait while another is streaming.
module cnn_ot_streamer #(
  parameter int IN       = 1,
  parameter int OCH      = 2,
  parameter int OX       = 2,
  parameter int OY       = 2,
  parameter int DATA_LEN = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_soft_reset,
  input  logic                             i_in_valid,
  input  logic [IN*OCH*OX*OY*DATA_LEN-1:0] i_in_fmap,
  cnn_ot_streamer_if.master                m_st,
  output logic                             o_busy,
  output logic                             o_overflow
);
  localparam int TOTAL = IN*OCH*OY*OX;
  localparam int FW    = TOTAL*DATA_LEN;
  localparam int XW    = (OX  > 1) ? $clog2(OX)  : 1;
  localparam int YW    = (OY  > 1) ? $clog2(OY)  : 1;
  localparam int CW    = (OCH > 1) ? $clog2(OCH) : 1;
  localparam int NW    = (IN  > 1) ? $clog2(IN)  : 1;
  localparam logic [XW-1:0] OX_MAX  = XW'(OX-1);
  localparam logic [YW-1:0] OY_MAX  = YW'(OY-1);
  localparam logic [CW-1:0] OCH_MAX = CW'(OCH-1);
  localparam logic [NW-1:0] IN_MAX  = NW'(IN-1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t          r_state, w_next_state;
  logic [FW-1:0]   r_cap;
  logic [XW-1:0]   r_ox;
  logic [YW-1:0]   r_oy;
  logic [CW-1:0]   r_och;
  logic [NW-1:0]   r_in;
  logic            r_overflow;

  logic            w_stream, w_hs, w_at_last, w_last_hs;
  logic            w_reload, w_load, w_drop, w_hold_occ;
  logic            w_valid, w_busy;
  logic [FW-1:0]   w_load_dat;

  assign w_stream  = (r_state == S_STREAM);
  assign w_hs      = w_stream && m_st.i_ready;
  assign w_at_last = (r_ox == OX_MAX) && (r_oy == OY_MAX) && (r_och == OCH_MAX) && (r_in == IN_MAX);
  assign w_last_hs = w_hs && w_at_last;
  assign w_load    = (!w_stream && i_in_valid) || (w_last_hs && w_reload);

`ifdef CNN_OT_STREAM_DBL_BUF_EN
  logic [FW-1:0] r_hold;
  logic          r_hold_vld;

  // A waiting frame always goes ahead of a strobe that arrives on the same last-element edge.
  assign w_reload   = r_hold_vld || i_in_valid;
  assign w_load_dat = r_hold_vld ? r_hold : i_in_fmap;
  assign w_drop     = w_stream && !w_last_hs && i_in_valid && r_hold_vld;
  assign w_hold_occ = r_hold_vld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
    end else if (i_soft_reset) begin
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
    end else if (w_last_hs) begin
      if (r_hold_vld) begin
        r_hold_vld <= i_in_valid;
        if (i_in_valid) r_hold <= i_in_fmap;
      end
    end else if (w_stream && i_in_valid && !r_hold_vld) begin
      r_hold     <= i_in_fmap;
      r_hold_vld <= 1'b1;
    end
  end
`else
  assign w_reload   = i_in_valid;
  assign w_load_dat = i_in_fmap;
  assign w_drop     = w_stream && !w_last_hs && i_in_valid;
  assign w_hold_occ = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    w_valid      = 1'b0;
    w_busy       = w_hold_occ;
    case (r_state)
      S_IDLE: begin
        if (i_in_valid) w_next_state = S_STREAM;
      end
      S_STREAM: begin
        w_valid = 1'b1;
        w_busy  = 1'b1;
        if (w_last_hs && !w_reload) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cap      <= '0;
      r_ox       <= '0;
      r_oy       <= '0;
      r_och      <= '0;
      r_in       <= '0;
      r_overflow <= 1'b0;
    end else if (i_soft_reset) begin
      r_state    <= S_IDLE;
      r_cap      <= '0;
      r_ox       <= '0;
      r_oy       <= '0;
      r_och      <= '0;
      r_in       <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_drop) r_overflow <= 1'b1;
      if (w_load) begin
        r_cap <= w_load_dat;
        r_ox  <= '0;
        r_oy  <= '0;
        r_och <= '0;
        r_in  <= '0;
      end else if (w_hs) begin
        // The frame shifts down so the current element always sits in the low bits.
        r_cap <= r_cap >> DATA_LEN;
        if (r_ox == OX_MAX) begin
          r_ox <= '0;
          if (r_oy == OY_MAX) begin
            r_oy <= '0;
            if (r_och == OCH_MAX) begin
              r_och <= '0;
              r_in  <= (r_in == IN_MAX) ? '0 : r_in + 1'b1;
            end else begin
              r_och <= r_och + 1'b1;
            end
          end else begin
            r_oy <= r_oy + 1'b1;
          end
        end else begin
          r_ox <= r_ox + 1'b1;
        end
      end
    end
  end

  assign m_st.o_valid   = w_valid;
  assign m_st.o_data    = r_cap[DATA_LEN-1:0];
  assign m_st.o_first   = w_stream && (r_ox == '0) && (r_oy == '0);
  assign m_st.o_last    = w_stream && w_at_last;
  assign m_st.o_idx_in  = r_in;
  assign m_st.o_idx_och = r_och;
  assign o_busy         = w_busy;
  assign o_overflow     = r_overflow;
endmodule

// File: tb/tb_cnn_ot_streamer.sv
// Directed bench for cnn_ot_streamer (IN=1, OCH=2, OX=2, OY=2, DATA_LEN=8) with an element scoreboard.
// Build with CNN_OT_STREAM_DBL_BUF_EN defined to exercise the holding register instead of the drop case.
module tb_cnn_ot_streamer;
  typedef struct packed {
    logic [7:0] d;
    logic       f;
    logic       l;
    logic       och;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_soft_reset;
  logic        i_in_valid;
  logic [63:0] i_in_fmap;
  logic        o_busy;
  logic        o_overflow;
  int          total = 0;
  int          bad   = 0;
  exp_t        sb[$];

  cnn_ot_streamer_if #(.DATA_LEN(8), .IN_W(1), .OCH_W(1)) st ();

  cnn_ot_streamer #(.IN(1), .OCH(2), .OX(2), .OY(2), .DATA_LEN(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_soft_reset (i_soft_reset),
    .i_in_valid   (i_in_valid),
    .i_in_fmap    (i_in_fmap),
    .m_st         (st.master),
    .o_busy       (o_busy),
    .o_overflow   (o_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_bus(input logic [7:0] base);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) v[k*8 +: 8] = base + 8'(k);
    return v;
  endfunction

  task automatic push_frame(input logic [7:0] base);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.d   = base + 8'(k);
      e.f   = (k % 4) == 0;
      e.l   = (k == 7);
      e.och = (k >= 4);
      sb.push_back(e);
    end
  endtask

  // Compares any handshake of the current cycle against the scoreboard, then advances one edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (st.o_valid && st.i_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_elem", 32'(st.o_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("data",    32'(st.o_data),    32'(e.d));
        chk("first",   32'(st.o_first),   32'(e.f));
        chk("last",    32'(st.o_last),    32'(e.l));
        chk("idx_och", 32'(st.o_idx_och), 32'(e.och));
        chk("idx_in",  32'(st.o_idx_in),  32'd0);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] base, input bit expect_frame);
    i_in_valid = 1'b1;
    i_in_fmap  = mk_bus(base);
    if (expect_frame) push_frame(base);
    tick();
    i_in_valid = 1'b0;
  endtask

  task automatic drain(input bit strict);
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin
      if (strict) chk("no_bubble", 32'(st.o_valid), 32'd1);
      tick();
    end
    chk("drained", 32'(sb.size()), 32'd0);
    chk("idle_valid", 32'(st.o_valid), 32'd0);
    chk("idle_busy",  32'(o_busy),     32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    i_soft_reset = 1'b0;
    i_in_valid   = 1'b0;
    i_in_fmap    = '0;
    st.i_ready   = 1'b1;
    #12;
    chk("rst_valid",    32'(st.o_valid),   32'd0);
    chk("rst_first",    32'(st.o_first),   32'd0);
    chk("rst_last",     32'(st.o_last),    32'd0);
    chk("rst_busy",     32'(o_busy),       32'd0);
    chk("rst_overflow", 32'(o_overflow),   32'd0);
    chk("rst_data",     32'(st.o_data),    32'd0);
    chk("rst_idx_och",  32'(st.o_idx_och), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();

    // Basic stream: element 0 one cycle after the strobe, then one element per cycle.
    strobe(8'h01, 1'b1);
    chk("latency_valid", 32'(st.o_valid), 32'd1);
    chk("latency_busy",  32'(o_busy),     32'd1);
    drain(1'b1);

    // Backpressure with ready pattern 1,0,0,1,0,0...
    strobe(8'h01, 1'b1);
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin
      st.i_ready = (i % 3) == 0;
      tick();
    end
    st.i_ready = 1'b1;
    chk("bp_drained", 32'(sb.size()), 32'd0);
    tick();
    chk("bp_idle", 32'(st.o_valid), 32'd0);

`ifdef CNN_OT_STREAM_DBL_BUF_EN
    // Second frame parks in the holding register, third strobe overflows.
    strobe(8'h01, 1'b1);
    tick();
    chk("dbl_elem2", 32'(st.o_data), 32'h02);
    strobe(8'h40, 1'b1);
    chk("dbl_no_ovf", 32'(o_overflow), 32'd0);
    strobe(8'hC0, 1'b0);
    chk("dbl_ovf", 32'(o_overflow), 32'd1);
    drain(1'b1);
`else
    // Strobe while streaming is dropped and flagged; the first frame completes intact.
    strobe(8'h01, 1'b1);
    tick();
    tick();
    chk("ovf_elem3", 32'(st.o_data), 32'h03);
    strobe(8'hA0, 1'b0);
    chk("ovf_set", 32'(o_overflow), 32'd1);
    drain(1'b1);
    chk("ovf_sticky", 32'(o_overflow), 32'd1);
`endif
    i_soft_reset = 1'b1;
    tick();
    i_soft_reset = 1'b0;
    chk("ovf_cleared", 32'(o_overflow), 32'd0);

    // Seamless restart: new strobe on the last handshake edge.
    strobe(8'h01, 1'b1);
    for (int i = 0; i < 7; i++) tick();
    chk("pre_last", 32'(st.o_last), 32'd1);
    strobe(8'hA0, 1'b1);
    chk("restart_valid", 32'(st.o_valid),  32'd1);
    chk("restart_data",  32'(st.o_data),   32'hA0);
    chk("restart_first", 32'(st.o_first),  32'd1);
    chk("restart_ovf",   32'(o_overflow),  32'd0);
    drain(1'b1);

    // Asynchronous reset mid-frame, then a fresh frame.
    strobe(8'h01, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    chk("mid_elem5", 32'(st.o_data), 32'h05);
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(st.o_valid), 32'd0);
    chk("arst_busy",  32'(o_busy),     32'd0);
    chk("arst_last",  32'(st.o_last),  32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    strobe(8'h01, 1'b1);
    chk("post_rst_data",  32'(st.o_data),  32'h01);
    chk("post_rst_first", 32'(st.o_first), 32'd1);
    drain(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
